muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the pipelined core. It owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU as a 32-iteration radix-2 operation beside the single-cycle ALU. It stalls the pipeline through `o_busy` and serves MFHI/MFLO reads and MTHI/MTLO writes in the EX stage.

## Interface
Parameters:
- `WIDTH`, 32, operand width; iteration count equals `WIDTH`.

Ports:
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_start`  in  1  launch the operation in `i_op` with operands `i_a` and `i_b`.
- `i_op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `i_a`, `i_b`  in  WIDTH  rs and rt operands; sampled only when a start is accepted.
- `i_flush`  in  1  abort the in-flight operation (branch or exception squash).
- `i_hilo_we`  in  1  MTHI/MTLO write strobe.
- `i_hilo_sel`  in  1  0 selects LO, 1 selects HI, for both write and read.
- `i_wdata`  in  WIDTH  MTHI/MTLO data.
- `o_busy`  out  1  operation in flight; the pipeline holds EX and earlier stages.
- `o_done`  out  1  one-cycle pulse when HI/LO have been updated.
- `o_rdata`  out  WIDTH  HI if `i_hilo_sel`=1, else LO; combinational from the registers.

## Operation
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- **IDLE.** If `i_start`=1 and `i_flush`=0, latch the op and operands and go to PREP.
  - If `i_start` and `i_hilo_we` are both high, the start wins and the write is dropped.
- **PREP.** Signed ops (MULT, DIV): record the result signs, then replace each operand by its absolute value. Unsigned ops pass operands through. Clear the 2·WIDTH accumulator and load the iteration counter with WIDTH-1. Go to ITER.
- **ITER.** Runs exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract, producing one quotient bit per cycle.
  - When the counter reaches 0, go to FIX. Otherwise decrement the counter.
- **FIX.** Apply signs.
  - Multiply: 64-bit two's-complement negate if the operand signs differ.
  - Divide: quotient sign is the XOR of the operand signs; remainder takes the sign of the dividend.
  - Write HI = upper half or remainder, LO = lower half or quotient. Go to DONE.
- **DONE.** `o_done`=1 for this one cycle, then go to IDLE.
- **Divide by zero.** Runs full length. Result is HI = `i_a` and LO = all-ones for both DIV and DIVU.
- **DIV 0x80000000 / 0xFFFFFFFF.** Result is LO = 0x80000000, HI = 0, with no exception raised.
- **`i_start` while not IDLE.** Ignored; the in-flight operation is unaffected.
- **`i_hilo_we` while busy.** Ignored; the pipeline guarantees it stalls.
- **`i_hilo_we` in IDLE.** Writes the selected register at the next edge.
- **`i_flush` in PREP, ITER or FIX.** Return to IDLE next edge with HI/LO unchanged and no `o_done`.
- **`i_flush` in DONE.** No effect, since HI/LO are already written.

## Timing
- **Reset values.** State IDLE, HI = 0, LO = 0, `o_busy`=0, `o_done`=0, counter 0. `o_rdata` is therefore 0 after reset.
- **Reset mid-operation.** Same as power-up reset; the partial result is discarded.
- **Latency.** Start accepted at edge 0 → PREP in cycle 1, ITER in cycles 2..33, FIX in cycle 34, DONE in cycle 35 (`o_done`=1). New HI/LO values are readable from cycle 35. IDLE resumes in cycle 36.
- **`o_busy`.** Combinational: 1 whenever the state is not IDLE, or when the state is IDLE with `i_start`=1. This stalls the issuing cycle itself, and stays high through DONE.
- **Back-to-back.** Throughput is one operation per 36 cycles. A start presented in the DONE cycle is ignored, because the pipeline is still held in that cycle.
- **Accumulator width.** 2·WIDTH+1 bits (the extra bit is the divide subtract borrow). Products are exact; no overflow is possible.

## Structure
- **Shared core package** holds:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`;
  - state encodings `MD_IDLE`, `MD_PREP`, `MD_ITER`, `MD_FIX`, `MD_DONE`;
  - `MD_WIDTH` = 32.
- **Sub-module `muldiv_step`.** Combinational single-iteration datapath. It takes the accumulator, divisor/multiplicand and an is-divide flag, and returns the next accumulator. The FSM, counter, sign handling and HI/LO registers stay in `muldiv_ctrl`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; `o_done` 35 cycles after start; `o_busy` high for cycles 0..35.
- MULT 0xFFFFFFFE (−2) × 3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- DIV −7 / 2 → LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). DIVU 7 / 0 → HI = 7, LO = 0xFFFFFFFF. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- MTLO 0x1234 in IDLE → `o_rdata` with sel=0 reads 0x1234 next cycle. MTHI pulsed during ITER → HI unchanged and the operation result stands.
- `i_flush` in cycle 20 of a DIV → IDLE next cycle, `o_done` never asserted, HI/LO hold their prior values. A new start the following cycle completes correctly.
- `i_rst` asserted in cycle 10 of a MULT → all outputs 0 next cycle. `i_start` held high while busy launches nothing extra: exactly one `o_done` pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_ITER = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Multiply layout: {carry, partial high, multiplier/low product}, shifting right.
// Divide layout:   {partial remainder (WIDTH+1), dividend/quotient}, shifting left.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc_i,
  input  logic [WIDTH-1:0]  opnd_i,
  input  logic              is_div_i,
  output logic [2*WIDTH:0]  acc_o
);

  logic [WIDTH:0]   hi_sum;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH+1:0] diff;

  // Next accumulator for either operation kind.
  always_comb begin
    hi_sum  = acc_i[2*WIDTH:WIDTH];
    shifted = {acc_i[2*WIDTH-1:0], 1'b0};
    diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, opnd_i};
    acc_o   = shifted;
    if (is_div_i) begin
      // No borrow means the divisor fits: keep the difference and emit a 1.
      if (!diff[WIDTH+1]) begin
        acc_o = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
      end
    end else begin
      if (acc_i[0]) begin
        hi_sum = acc_i[2*WIDTH:WIDTH] + {1'b0, opnd_i};
      end
      acc_o = {1'b0, hi_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and 32-iteration multiply/divide sequencer beside the ALU.
// Signed ops run on magnitudes; signs are reapplied in FIX.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  input  logic             i_hilo_we,
  input  logic             i_hilo_sel,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ACC_W = 2 * WIDTH + 1;

  md_state_e               state_q;
  md_op_e                  op_q;
  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic [WIDTH-1:0]        dvs_q;
  logic                    neg_res_q;
  logic                    neg_rem_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH-1:0]        hi_q;
  logic [WIDTH-1:0]        lo_q;
  logic                    done_q;

  logic                    is_div;
  logic                    sgn_a_d;
  logic                    sgn_b_d;
  logic [WIDTH-1:0]        mag_a_d;
  logic [WIDTH-1:0]        mag_b_d;
  logic [WIDTH-1:0]        hi_d;
  logic [WIDTH-1:0]        lo_d;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign is_div = md_is_div(op_q);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (dvs_q),
    .is_div_i (is_div),
    .acc_o    (acc_d)
  );

  // Operand signs and magnitudes used when entering the iteration phase.
  always_comb begin
    sgn_a_d = md_is_signed(op_q) & a_q[WIDTH-1];
    sgn_b_d = md_is_signed(op_q) & b_q[WIDTH-1];
    mag_a_d = sgn_a_d ? neg_w(a_q) : a_q;
    mag_b_d = sgn_b_d ? neg_w(b_q) : b_q;
  end

  // Signed fix-up of the raw accumulator into HI/LO.
  // A zero divisor bypasses it: HI returns the dividend, LO all-ones.
  always_comb begin
    hi_d = acc_q[2*WIDTH-1:WIDTH];
    lo_d = acc_q[WIDTH-1:0];
    if (is_div) begin
      if (b_q == '0) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        lo_d = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      end
    end else if (neg_res_q) begin
      {hi_d, lo_d} = neg_2w(acc_q[2*WIDTH-1:0]);
    end
  end

  // Sequencer FSM, HI/LO registers and the registered done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MD_IDLE: begin
          if (i_start && !i_flush) begin
            op_q    <= md_op_e'(i_op);
            a_q     <= i_a;
            b_q     <= i_b;
            state_q <= MD_PREP;
          end else if (i_hilo_we && !i_start) begin
            if (i_hilo_sel) hi_q <= i_wdata;
            else            lo_q <= i_wdata;
          end
        end
        MD_PREP: begin
          if (i_flush) begin
            state_q <= MD_IDLE;
          end else begin
            neg_res_q <= sgn_a_d ^ sgn_b_d;
            neg_rem_q <= sgn_a_d;
            dvs_q     <= mag_b_d;
            acc_q     <= {{(WIDTH+1){1'b0}}, mag_a_d};
            cnt_q     <= CNT_W'(WIDTH - 1);
            state_q   <= MD_ITER;
          end
        end
        MD_ITER: begin
          if (i_flush) begin
            state_q <= MD_IDLE;
          end else begin
            acc_q <= acc_d;
            if (cnt_q == '0) state_q <= MD_FIX;
            else             cnt_q   <= cnt_q - 1'b1;
          end
        end
        MD_FIX: begin
          if (i_flush) begin
            state_q <= MD_IDLE;
          end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            state_q <= MD_DONE;
          end
        end
        MD_DONE: begin
          state_q <= MD_IDLE;
        end
        default: begin
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

  assign o_busy  = (state_q != MD_IDLE) || i_start;
  assign o_done  = done_q;
  assign o_rdata = i_hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus multi-cycle corner sequences.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_flush, i_hilo_we, i_hilo_sel;
  logic [1:0]  i_op;
  logic [31:0] i_a, i_b, i_wdata;
  logic        o_busy, o_done;
  logic [31:0] o_rdata;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  muldiv_ctrl #(.WIDTH(32)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_flush    (i_flush),
    .i_hilo_we  (i_hilo_we),
    .i_hilo_sel (i_hilo_sel),
    .i_wdata    (i_wdata),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rdata    (o_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    i_hilo_sel = 1'b0;
    #1 lo = o_rdata;
    i_hilo_sel = 1'b1;
    #1 hi = o_rdata;
    i_hilo_sel = 1'b0;
  endtask

  // kind: 0 none, 1 flush at cycle inj, 2 reset at cycle inj, 3 MTHI at cycle inj,
  //       4 start held through cycle 35, 5 MTLO alongside the start
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int kind, input int inj,
                        output int busy0, output int done_cyc, output int n_done,
                        output int busy_end);
    @(posedge clk); #1;
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    i_hilo_we = (kind == 5); i_hilo_sel = 1'b0; i_wdata = 32'h5555AAAA;
    @(negedge clk);
    busy0 = o_busy;
    done_cyc = -1; n_done = 0; busy_end = -1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      i_start    = (kind == 4) && (k <= 35);
      i_a        = 32'hDEADBEEF;
      i_b        = 32'h0BADF00D;
      i_flush    = (kind == 1) && (k == inj);
      i_rst      = (kind == 2) && (k == inj);
      i_hilo_we  = (kind == 3) && (k == inj);
      i_hilo_sel = 1'b1;
      i_wdata    = 32'hDEAD0000;
      @(negedge clk);
      if (o_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (!o_busy && busy_end < 0) busy_end = k;
    end
    i_start = 1'b0; i_flush = 1'b0; i_rst = 1'b0; i_hilo_we = 1'b0; i_hilo_sel = 1'b0;
  endtask

  initial begin
    logic [31:0] hi, lo;
    int b0, dc, nd, be;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[6]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF};
    vecs[12] = '{2'b01, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF};

    i_rst = 1'b1; i_start = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
    i_flush = 1'b0; i_hilo_we = 1'b0; i_hilo_sel = 1'b0; i_wdata = '0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'b0, o_busy}, 32'd0);
    check("reset_done", {31'b0, o_done}, 32'd0);
    read_hilo(hi, lo);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // MTLO / MTHI in IDLE
    @(posedge clk); #1 i_hilo_we = 1'b1; i_hilo_sel = 1'b0; i_wdata = 32'h00001234;
    @(posedge clk); #1 i_hilo_we = 1'b1; i_hilo_sel = 1'b1; i_wdata = 32'hABCD5678;
    @(posedge clk); #1 i_hilo_we = 1'b0;
    @(negedge clk);
    read_hilo(hi, lo);
    check("mtlo", lo, 32'h00001234);
    check("mthi", hi, 32'hABCD5678);

    for (int v = 0; v < 13; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, 0, 0, b0, dc, nd, be);
      read_hilo(hi, lo);
      check($sformatf("v%0d_hi", v), hi, vecs[v].hi);
      check($sformatf("v%0d_lo", v), lo, vecs[v].lo);
      check($sformatf("v%0d_done_cycle", v), dc, 32'd35);
      check($sformatf("v%0d_done_count", v), nd, 32'd1);
      check($sformatf("v%0d_busy_issue", v), b0, 32'd1);
      check($sformatf("v%0d_busy_release", v), be, 32'd36);
    end

    // MTHI pulsed during ITER is ignored
    run_op(2'b01, 32'd3, 32'd5, 3, 10, b0, dc, nd, be);
    read_hilo(hi, lo);
    check("mthi_busy_hi", hi, 32'd0);
    check("mthi_busy_lo", lo, 32'd15);
    check("mthi_busy_done", dc, 32'd35);

    // Flush in cycle 20 of a DIV, then an immediate new start
    run_op(2'b10, 32'd100, 32'd7, 1, 20, b0, dc, nd, be);
    read_hilo(hi, lo);
    check("flush_no_done", nd, 32'd0);
    check("flush_idle", be, 32'd21);
    check("flush_hi_kept", hi, 32'd0);
    check("flush_lo_kept", lo, 32'd15);
    run_op(2'b11, 32'd100, 32'd7, 0, 0, b0, dc, nd, be);
    read_hilo(hi, lo);
    check("after_flush_hi", hi, 32'd2);
    check("after_flush_lo", lo, 32'd14);
    check("after_flush_done", dc, 32'd35);

    // Reset in cycle 10 of a MULT
    run_op(2'b00, 32'h0000FFFF, 32'h0000FFFF, 2, 10, b0, dc, nd, be);
    read_hilo(hi, lo);
    check("rst_busy_low", be, 32'd11);
    check("rst_no_done", nd, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // Start held high through the DONE cycle: exactly one operation
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, 4, 0, b0, dc, nd, be);
    read_hilo(hi, lo);
    check("hold_done_count", nd, 32'd1);
    check("hold_done_cycle", dc, 32'd35);
    check("hold_busy_release", be, 32'd36);
    check("hold_hi", hi, 32'hFFFFFFFF);
    check("hold_lo", lo, 32'hFFFFFFFA);

    // Start and MTLO together: start wins, the write is dropped
    run_op(2'b11, 32'd7, 32'd0, 5, 0, b0, dc, nd, be);
    read_hilo(hi, lo);
    check("start_we_hi", hi, 32'd7);
    check("start_we_lo", lo, 32'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
